// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated load/store responder on an internal byte-laned word RAM
module dmem_responder #(
  parameter int ADDR_W = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [31:0] dad,
  input  logic [31:0] ddt_in,
  output logic [31:0] ddt_out,
  output logic        ack,
  output logic        err,
  output logic        busy
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic l_we, l_uns;
  logic [1:0] l_size;
  logic [31:0] l_dad, l_din;
  logic c_we, c_uns, commit, bad;
  logic [1:0] c_size, lane;
  logic [31:0] c_dad, c_din, wdata, word, sh, ld;
  logic [ADDR_W-3:0] idx;
  logic [3:0] be;
  logic [31:0] mem [DEPTH];
  assign busy = state != IDLE;
  // Access decode on the captured request; live inputs stand in when committing straight from IDLE
  always_comb begin
    c_we = state == IDLE ? we : l_we;
    c_uns = state == IDLE ? ld_unsigned : l_uns;
    c_size = state == IDLE ? size : l_size;
    c_dad = state == IDLE ? dad : l_dad;
    c_din = state == IDLE ? ddt_in : l_din;
    commit = (state == IDLE && req && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1);
    lane = c_dad[1:0];
    idx = c_dad[ADDR_W-1:2];
    bad = c_size == 2'b11 || (c_size == 2'b01 && c_dad[0]) || (c_size == 2'b10 && lane != 2'b00) ||
          (c_dad >> ADDR_W) != '0;
    be = c_size == 2'b00 ? 4'b0001 << lane : c_size == 2'b01 ? 4'b0011 << lane : 4'b1111;
    wdata = c_size == 2'b00 ? {4{c_din[7:0]}} : c_size == 2'b01 ? {2{c_din[15:0]}} : c_din;
    word = mem[idx];
    sh = word >> {lane, 3'b000};
    ld = c_size == 2'b00 ? {{24{~c_uns & sh[7]}}, sh[7:0]} :
         c_size == 2'b01 ? {{16{~c_uns & sh[15]}}, sh[15:0]} : sh;
  end
  // Byte-lane store on the commit edge; reset on that edge drops the store
  always_ff @(posedge clk)
    if (!rst && commit && !bad && c_we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
  // Request FSM: capture, count wait states, then a single-cycle response
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ack <= 1'b0;
      err <= 1'b0;
      ddt_out <= '0;
    end else begin
      ack <= commit;
      if (commit) begin
        err <= bad;
        ddt_out <= (bad || c_we) ? '0 : ld;
      end
      case (state)
        IDLE: if (req) begin
          l_we <= we;
          l_uns <= ld_unsigned;
          l_size <= size;
          l_dad <= dad;
          l_din <= ddt_in;
          cnt <= 4'(WAIT_CYCLES);
          state <= WAIT_CYCLES == 0 ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
